// File: rtl/chunked_sub_pkg.sv
// Shared definitions for the chunked sequential subtractor: FSM states and default widths.
// Latency: none (declarations only).
// Backpressure: not applicable.
package chunked_sub_pkg;

  localparam int default_data_width  = 32;
  localparam int default_chunk_width = 8;

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

endpackage

// File: rtl/chunk_sub.sv
// One chunk of a ripple subtract: {borrow_out, diff} = a_i - b_i - borrow_in.
// Latency: purely combinational.
// Backpressure: not applicable.
module chunk_sub
  import chunked_sub_pkg::*;
#(
  parameter int chunk_width = default_chunk_width
) (
  input  logic [chunk_width-1:0] a_i,
  input  logic [chunk_width-1:0] b_i,
  input  logic                   borrow_in,
  output logic [chunk_width-1:0] diff,
  output logic                   borrow_out
);

  // One extra bit catches the borrow: a negative result sets the top bit.
  logic [chunk_width:0] wide;

  assign wide       = {1'b0, a_i} - {1'b0, b_i} - {{chunk_width{1'b0}}, borrow_in};
  assign diff       = wide[chunk_width-1:0];
  assign borrow_out = wide[chunk_width];

endmodule

// File: rtl/chunked_sub_seq.sv
// Sequential a - b, one chunk_width slice per cycle through a single shared chunk subtractor.
// Latency: req accepted at edge E0 -> ack pulse in the cycle after edge E0 + num_chunks.
// Backpressure: req is ignored while busy; req in the ack cycle starts the next operation.
module chunked_sub_seq
  import chunked_sub_pkg::*;
#(
  parameter int data_width  = default_data_width,
  parameter int chunk_width = default_chunk_width
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic [data_width-1:0] a,
  input  logic [data_width-1:0] b,
  output logic                  busy,
  output logic                  ack,
  output logic [data_width-1:0] out,
  output logic                  borrow
);

  localparam int num_chunks = data_width / chunk_width;
  localparam int idx_w      = (num_chunks > 1) ? $clog2(num_chunks) : 1;
  localparam logic [idx_w-1:0] last_idx = idx_w'(num_chunks - 1);

  state_t state, state_nxt;

  logic [data_width-1:0]  a_q, b_q;
  logic [data_width-1:0]  res_q, res_nxt;
  logic [idx_w-1:0]       idx;
  logic                   brw_q;
  logic [31:0]            base;
  logic [chunk_width-1:0] a_i, b_i, diff;
  logic                   borrow_in, borrow_out;
  logic                   accept, done;

  // Slice selection: the index mux in front of the shared chunk subtractor.
  assign base      = 32'(idx) * 32'(chunk_width);
  assign a_i       = a_q[base +: chunk_width];
  assign b_i       = b_q[base +: chunk_width];
  assign borrow_in = (idx == '0) ? 1'b0 : brw_q;

  chunk_sub #(
    .chunk_width(chunk_width)
  ) u_chunk_sub (
    .a_i       (a_i),
    .b_i       (b_i),
    .borrow_in (borrow_in),
    .diff      (diff),
    .borrow_out(borrow_out)
  );

  // Merge this cycle's chunk into the partial result held off the output.
  always_comb begin
    res_nxt = res_q;
    res_nxt[base +: chunk_width] = diff;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic, busy, and the accept/done strobes for the datapath.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    accept    = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          accept    = 1'b1;
          state_nxt = CALC;
        end
      end
      CALC: begin
        busy = 1'b1;
        if (idx == last_idx) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, per-chunk accumulation, and publishing of the final result.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      res_q  <= '0;
      idx    <= '0;
      brw_q  <= 1'b0;
      ack    <= 1'b0;
      out    <= '0;
      borrow <= 1'b0;
    end else begin
      ack <= done;
      if (accept) begin
        a_q   <= a;
        b_q   <= b;
        idx   <= '0;
        brw_q <= 1'b0;
      end else if (busy) begin
        res_q <= res_nxt;
        brw_q <= borrow_out;
        idx   <= idx + 1'b1;
      end
      // out only changes on completion, so partial chunks never leak.
      if (done) begin
        out    <= res_nxt;
        borrow <= borrow_out;
      end
    end
  end

endmodule
